// File: rtl/uart_tx_mmio_if.sv
// CPU-side IO bus for the memory-mapped UART transmitter: word select, write and
// read strobes, byte-lane mask, store data and registered read data.
interface uart_tx_mmio_if;
  logic [1:0]  io_addr;
  logic        io_wstrb;
  logic [3:0]  io_wmask;
  logic [31:0] io_wdata;
  logic        io_rstrb;
  logic [31:0] io_rdata;

  modport master (
    output io_addr, io_wstrb, io_wmask, io_wdata, io_rstrb,
    input  io_rdata
  );

  modport slave (
    input  io_addr, io_wstrb, io_wmask, io_wdata, io_rstrb,
    output io_rdata
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte stores to DATA go through a small FIFO
// and are serialised on ftdi_txd; STATUS exposes overflow/empty/full/busy.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           ftdi_txd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic [7:0]    r_shift;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic          r_overflow;
  logic          r_txd;
  logic [31:0]   r_rdata;

  logic       w_full;
  logic       w_empty;
  logic       w_busy;
  logic       w_push_req;
  logic       w_push;
  logic       w_pop;
  logic       w_bit_end;
  logic       w_ovf_clr;
  logic [7:0] w_head;
  logic       w_unused;

  assign w_full     = (r_count == FULL_COUNT);
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE) || !w_empty;
  assign w_push_req = bus.io_wstrb && (bus.io_addr == 2'd0) && bus.io_wmask[0];
  assign w_push     = w_push_req && !w_full;
  assign w_ovf_clr  = bus.io_wstrb && (bus.io_addr == 2'd1) && bus.io_wmask[0] && bus.io_wdata[3];
  assign w_bit_end  = (r_bit_cnt == BIT_LAST);
  // Pop only when the line is free: from IDLE, or at the last cycle of a stop bit.
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head     = r_mem[r_rptr];
  assign w_unused   = &{1'b0, bus.io_wmask[3:1], bus.io_wdata[31:8]};

  assign ftdi_txd    = r_txd;
  assign bus.io_rdata = r_rdata;

  // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.io_wdata[7:0];
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: ;
      endcase
      if (w_push_req && w_full) r_overflow <= 1'b1;
      else if (w_ovf_clr)       r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (bus.io_rstrb) begin
      r_rdata <= (bus.io_addr == 2'd1) ? {28'b0, r_overflow, w_empty, w_full, w_busy} : 32'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_txd     <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift   <= w_head;
            r_bit_cnt <= '0;
            r_txd     <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_txd     <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_txd     <= r_shift[1];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: frame-level reference model plus a line
// decoder, a table of bus vectors, hand-written corner sequences and random traffic.
module tb_uart_tx_mmio;

  localparam int C = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ftdi_txd;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ftdi_txd (ftdi_txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents, current frame byte and position within the frame.
  logic [7:0]  m_q[$];
  logic [7:0]  m_txlog[$];
  logic        m_active;
  int          m_t;
  logic [7:0]  m_cur;
  logic        m_ovf;
  logic [31:0] m_rdata;

  // Independent line decoder sampling mid-bit.
  logic [7:0] rx_q[$];
  logic       rx_busy;
  int         rx_n;
  logic [7:0] rx_byte;

  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic        wstrb;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        rstrb;
    logic [31:0] exp_rdata;
    logic        exp_txd;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_cur    = '0;
    m_ovf    = 1'b0;
    m_rdata  = '0;
    rx_busy  = 1'b0;
    rx_n     = 0;
  endtask

  task automatic model_step();
    int   cnt;
    logic full, empty, busy, line_free;
    if (rst) begin
      model_reset();
      return;
    end
    cnt   = m_q.size();
    full  = (cnt == D);
    empty = (cnt == 0);
    busy  = m_active || !empty;
    if (bus.io_rstrb)
      m_rdata = (bus.io_addr == 2'd1) ? {28'b0, m_ovf, empty, full, busy} : 32'h0;
    line_free = !m_active;
    if (m_active) begin
      m_t++;
      if (m_t == 10 * C) begin
        m_active  = 1'b0;
        line_free = 1'b1;
      end
    end
    if (line_free && !empty) begin
      m_cur = m_q.pop_front();
      m_txlog.push_back(m_cur);
      m_active = 1'b1;
      m_t      = 0;
    end
    if (bus.io_wstrb && bus.io_wmask[0]) begin
      if (bus.io_addr == 2'd0) begin
        if (full) m_ovf = 1'b1;
        else      m_q.push_back(bus.io_wdata[7:0]);
      end else if (bus.io_addr == 2'd1 && bus.io_wdata[3]) begin
        m_ovf = 1'b0;
      end
    end
  endtask

  task automatic rx_sample();
    int k;
    if (!rx_busy) begin
      if (ftdi_txd == 1'b0) begin
        rx_busy = 1'b1;
        rx_n    = 0;
      end
    end else begin
      rx_n++;
      k = rx_n / C;
      if ((rx_n % C) == (C / 2) && k >= 1 && k <= 8) rx_byte[k-1] = ftdi_txd;
      if (rx_n == 9 * C + C / 2) begin
        rx_busy = 1'b0;
        rx_q.push_back(rx_byte);
      end
    end
  endtask

  task automatic idle_bus();
    bus.io_addr  = 2'd0;
    bus.io_wstrb = 1'b0;
    bus.io_wmask = 4'h0;
    bus.io_wdata = 32'h0;
    bus.io_rstrb = 1'b0;
  endtask

  task automatic drive(input logic [1:0] addr, input logic wstrb, input logic [3:0] wmask,
                       input logic [31:0] wdata, input logic rstrb);
    bus.io_addr  = addr;
    bus.io_wstrb = wstrb;
    bus.io_wmask = wmask;
    bus.io_wdata = wdata;
    bus.io_rstrb = rstrb;
  endtask

  // One clock: model advances on the edge, DUT compared on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("txd", ftdi_txd, exp_txd());
    check("rdata", bus.io_rdata, m_rdata);
    rx_sample();
    idle_bus();
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    drive(addr, 1'b1, 4'b0001, data, 1'b0);
    cycle();
  endtask

  task automatic rd(input logic [1:0] addr);
    drive(addr, 1'b0, 4'h0, 32'h0, 1'b1);
    cycle();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_active || m_q.size() != 0) && n < 2000) begin
      cycle();
      n++;
    end
    check({name, "_drain_timeout"}, {31'b0, (m_active || m_q.size() != 0)}, 32'h0);
  endtask

  task automatic check_rx(input string name);
    check({name, "_rx_count"}, rx_q.size(), m_txlog.size());
    for (int i = 0; i < rx_q.size() && i < m_txlog.size(); i++)
      check({name, "_rx_byte"}, rx_q[i], m_txlog[i]);
  endtask

  task automatic clear_logs();
    rx_q.delete();
    m_txlog.delete();
  endtask

  task automatic add_vec(input string name, input logic [1:0] addr, input logic wstrb,
                         input logic [3:0] wmask, input logic [31:0] wdata, input logic rstrb,
                         input logic [31:0] exp_rdata, input logic exp_txd_v);
    vec_t v;
    v.name = name; v.addr = addr; v.wstrb = wstrb; v.wmask = wmask; v.wdata = wdata;
    v.rstrb = rstrb; v.exp_rdata = exp_rdata; v.exp_txd = exp_txd_v;
    vq.push_back(v);
  endtask

  logic [7:0] exp_byte;
  logic       exp_bit;

  initial begin
    idle_bus();
    model_reset();

    // Reset defaults
    rst = 1'b1;
    repeat (3) cycle();
    check("reset_txd", ftdi_txd, 1'b1);
    check("reset_rdata", bus.io_rdata, 32'h0);
    rst = 1'b0;

    // Table: register map, masked / unmapped writes, first-frame latency
    add_vec("rd_status_reset",  2'd1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h4, 1'b1);
    add_vec("masked_data_wr",   2'd0, 1'b1, 4'b0010, 32'h55,    1'b0, 32'h4, 1'b1);
    add_vec("rd_after_masked",  2'd1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h4, 1'b1);
    add_vec("rd_unmapped2",     2'd2, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0, 1'b1);
    add_vec("wr_unmapped3",     2'd3, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
    add_vec("rd_after_unm3",    2'd1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h4, 1'b1);
    add_vec("wr_rd_unmapped2",  2'd2, 1'b1, 4'b0001, 32'h41,    1'b1, 32'h0, 1'b1);
    add_vec("rd_after_unm2",    2'd1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h4, 1'b1);
    add_vec("wr_status_clr",    2'd1, 1'b1, 4'b0001, 32'h8,     1'b0, 32'h4, 1'b1);
    add_vec("wr_data_rd_data",  2'd0, 1'b1, 4'b0001, 32'h3C,    1'b1, 32'h0, 1'b1);
    add_vec("rd_status_queued", 2'd1, 1'b0, 4'h0, 32'h0,       1'b1, 32'h1, 1'b0);
    add_vec("rd_status_start",  2'd1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h5, 1'b0);
    add_vec("rd_data_zero",     2'd0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0, 1'b0);

    clear_logs();
    foreach (vq[i]) begin
      drive(vq[i].addr, vq[i].wstrb, vq[i].wmask, vq[i].wdata, vq[i].rstrb);
      cycle();
      check({vq[i].name, "_rdata"}, bus.io_rdata, vq[i].exp_rdata);
      check({vq[i].name, "_txd"}, ftdi_txd, vq[i].exp_txd);
    end
    wait_idle("table");
    check("table_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("table_rx_byte", rx_q[0], 32'h3C);

    // Single frame: 0x55, exact 40-cycle waveform
    repeat (3) cycle();
    clear_logs();
    exp_byte = 8'h55;
    wr(2'd0, 32'h55);
    for (int i = 0; i < 10 * C; i++) begin
      cycle();
      if (i < C)            exp_bit = 1'b0;
      else if (i >= 9 * C)  exp_bit = 1'b1;
      else                  exp_bit = exp_byte[(i - C) / C];
      check("frame55_bit", ftdi_txd, exp_bit);
    end
    rd(2'd1);
    check("frame55_busy_last_edge", bus.io_rdata, 32'h5);
    rd(2'd1);
    check("frame55_status_after", bus.io_rdata, 32'h4);
    check("frame55_rx", rx_q.size() == 1 ? rx_q[0] : 8'hxx, 32'h55);

    // Back-to-back: five consecutive writes, 200 cycles of gapless frames
    clear_logs();
    for (int b = 1; b <= 5; b++) wr(2'd0, 32'(b));
    rd(2'd1);
    check("b2b_status_full", bus.io_rdata, 32'h3);
    repeat (195) cycle();
    rd(2'd1);
    check("b2b_busy_at_200", bus.io_rdata, 32'h5);
    rd(2'd1);
    check("b2b_idle_after_200", bus.io_rdata, 32'h4);
    check("b2b_rx_count", rx_q.size(), 5);
    for (int b = 0; b < rx_q.size() && b < 5; b++) check("b2b_rx_byte", rx_q[b], 32'(b + 1));

    // Overflow: fill during a frame, drop 0xAA, clear the sticky flag
    clear_logs();
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    wr(2'd0, 32'h33);
    wr(2'd0, 32'h44);
    wr(2'd0, 32'h55);
    wr(2'd0, 32'hAA);
    rd(2'd1);
    check("ovf_status_set", bus.io_rdata, 32'hB);
    drive(2'd1, 1'b1, 4'b0001, 32'h8, 1'b1);
    cycle();
    check("ovf_read_prewrite", bus.io_rdata, 32'hB);
    rd(2'd1);
    check("ovf_status_cleared", bus.io_rdata, 32'h3);
    wait_idle("ovf");
    rd(2'd1);
    check("ovf_status_idle", bus.io_rdata, 32'h4);
    check("ovf_rx_count", rx_q.size(), 5);
    for (int b = 0; b < rx_q.size() && b < 5; b++)
      check("ovf_rx_byte", rx_q[b], 32'h11 * (b + 1));

    // Reset mid-frame: during bit 3 of 0xF0 with two bytes queued
    clear_logs();
    wr(2'd0, 32'hF0);
    wr(2'd0, 32'hA1);
    wr(2'd0, 32'hB2);
    repeat (16) cycle();
    check("mid_frame_bit3_low", ftdi_txd, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_txd_immediate", ftdi_txd, 1'b1);
    check("rst_rdata_immediate", bus.io_rdata, 32'h0);
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    clear_logs();
    repeat (60) cycle();
    rd(2'd1);
    check("rst_status_after", bus.io_rdata, 32'h4);
    check("rst_no_frame", rx_q.size(), 0);

    // Random traffic against the reference model
    clear_logs();
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] a;
      r = $urandom_range(0, 9);
      a = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      drive(a, ($urandom_range(0, 3) == 0), 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
      cycle();
      if ((n % 500) == 499) wait_idle("rand_quiet");
    end
    wait_idle("rand");
    check_rx("rand");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
